controller_data_ram_mover: RTL

Avalon-MM master that drives the second port (s2) of the controller's 2048×32 dual-port data RAM. It moves blocks between that RAM and 32-bit Avalon-ST streams. In read mode it fetches a run of consecutive words and streams them out under backpressure. In write mode it accepts stream words and stores them at consecutive addresses. The block sits beside the Nios-side port (s1), so firmware-visible buffers can be filled or drained by hardware.

---
 rtl/controller_data_ram_mover.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/controller_data_ram_mover.sv
// controller_data_ram_mover
//   Avalon-MM master on port s2 of the 2048x32 controller data RAM. It moves
//   blocks between the RAM and 32-bit Avalon-ST streams.
//   Read mode:  fetches consecutive words into a small return FIFO and streams
//               them out on src_* under backpressure.
//   Write mode: stores words accepted on snk_* at consecutive addresses.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   cmd_valid/ready/write/address/length   command handshake (length 0..4095)
//   busy, done                       status; done is a one-cycle pulse
//   src_valid/ready/data             read-data stream (out)
//   snk_valid/ready/data             write-data stream (in)
//   ram_address/chipselect/write/byteenable/writedata/readdata/clken
//                                    RAM port 2; all outputs registered
module controller_data_ram_mover #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [10:0] cmd_address,
    input  logic [11:0] cmd_length,
    output logic        busy,
    output logic        done,
    output logic        src_valid,
    input  logic        src_ready,
    output logic [31:0] src_data,
    input  logic        snk_valid,
    output logic        snk_ready,
    input  logic [31:0] snk_data,
    output logic [10:0] ram_address,
    output logic        ram_chipselect,
    output logic        ram_write,
    output logic [3:0]  ram_byteenable,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata,
    output logic        ram_clken
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 3) + 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StDrain, StDone} state_e;

    state_e         state_q, state_d;
    logic [10:0]    addr_q;
    logic [11:0]    remain_q;          // accesses still to issue
    logic           rd1_q, rd2_q;      // read on the RAM bus / read data returning now
    logic [10:0]    ram_address_q;
    logic           ram_chipselect_q;
    logic           ram_write_q;
    logic [31:0]    ram_writedata_q;

    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic           push, pop, issue_rd, wr_hs;
    logic [CntW-1:0] in_flight;

    assign push      = rd2_q;
    assign pop       = (count_q != '0) && src_ready;
    // Words already buffered plus reads still in the RAM pipeline; a new read is
    // only issued when its return slot is guaranteed.
    assign in_flight = count_q + CntW'(rd1_q) + CntW'(rd2_q);

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        snk_ready = 1'b0;
        issue_rd  = 1'b0;
        wr_hs     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_length == '0) state_d = StDone;
                    else if (cmd_write)   state_d = StWrite;
                    else                  state_d = StRead;
                end
            end
            StRead: begin
                issue_rd = (remain_q != '0) && ((in_flight - CntW'(pop)) < DepthC);
                if (issue_rd && (remain_q == 12'd1)) state_d = StDrain;
            end
            StDrain: begin
                if (!rd1_q && !rd2_q && (count_q == CntW'(pop))) state_d = StDone;
            end
            StWrite: begin
                snk_ready = (remain_q != '0);
                wr_hs     = snk_ready && snk_valid;
                // remain_q reaches 0 in the cycle the last write is on the bus
                if (remain_q == '0) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            addr_q           <= '0;
            remain_q         <= '0;
            rd1_q            <= 1'b0;
            rd2_q            <= 1'b0;
            ram_address_q    <= '0;
            ram_chipselect_q <= 1'b0;
            ram_write_q      <= 1'b0;
            ram_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            rd1_q            <= issue_rd;
            rd2_q            <= rd1_q;
            ram_chipselect_q <= issue_rd || wr_hs;
            ram_write_q      <= wr_hs;
            if (state_q == StIdle && cmd_valid) begin
                addr_q   <= cmd_address;
                remain_q <= cmd_length;
            end else if (issue_rd || wr_hs) begin
                ram_address_q <= addr_q;
                addr_q        <= addr_q + 11'd1;   // wraps 0x7FF -> 0x000
                remain_q      <= remain_q - 12'd1;
            end
            if (wr_hs) ram_writedata_q <= snk_data;
        end
    end

    // Read-return FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= ram_readdata;
    end

    assign src_valid      = (count_q != '0);
    assign src_data       = src_valid ? fifo_mem[rd_ptr_q] : '0;
    assign ram_address    = ram_address_q;
    assign ram_chipselect = ram_chipselect_q;
    assign ram_write      = ram_write_q;
    assign ram_writedata  = ram_writedata_q;
    assign ram_byteenable = 4'hF;
    assign ram_clken      = 1'b1;

endmodule
